alu_imm_iq_gen2: RTL and testbench

Second-generation issue queue for ALU register-immediate ops. It is parametrised in queue depth, physical register count, ROB size and PRF bank count. It holds renamed ops until operand A is ready, wakes them up from the banked writeback bus, and issues the oldest ready op to the ALU-imm pipeline along with a PRF read request. It adds ROB-relative flush (kill of the flush index and everything younger) and a compile-time same-cycle writeback forward path.

---
 rtl/alu_imm_iq_gen2.sv | 260 ++++++++++++++++++++++++++
 tb/tb_alu_imm_iq_gen2.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_imm_iq_gen2.sv
// -----------------------------------------------------------------------------
// alu_imm_iq_gen2
//
// Issue queue for ALU register-immediate ops. It holds renamed ops until
// operand A is ready and wakes them from the banked writeback bus. Each cycle
// it offers the oldest ready op to the ALU-imm pipeline, together with a PRF
// read request for A. A ROB-relative flush kills the flush index and every
// younger op.
//
// Storage is a collapsing queue with entry 0 as the oldest entry. Valid
// entries are always contiguous from entry 0.
//
// Compile-time option:
//   ALU_IMM_IQ_WB_FORWARD_EN - when defined, an entry whose operand is being
//   written back this cycle may issue in the same cycle. It then takes A from
//   the bus (issue_A_forward=1) and no PRF read is requested. When undefined,
//   only the registered A_ready bit makes an entry eligible and
//   issue_A_forward is tied to 0.
//
// Handshakes (both channels): a transfer happens on a rising CLK edge where
// valid and ready are both high. valid never depends on ready in the same
// direction. Here iq_enq_ready does not look at iq_enq_valid, and issue_valid
// does not look at issue_ready.
//
// Ports:
//   CLK, nRST                 clock, asynchronous active-low reset
//   iq_enq_*                  enqueue channel (op, imm12, A_PR, A_ready,
//                             dest_PR, ROB_index); iq_enq_ready is the accept
//   WB_bus_valid_by_bank      writeback valid, one bit per PRF bank
//   WB_bus_upper_PR_by_bank   upper PR bits written back, per bank
//   issue_*                   issue channel to the ALU-imm pipeline;
//                             issue_ready is the pipeline accept
//   PRF_req_A_valid/_PR       PRF read request for operand A of the issued op
//   flush_valid/_ROB_index    kill this ROB index and everything younger
//   ROB_head_index            oldest ROB index, used as the age reference
// -----------------------------------------------------------------------------
module alu_imm_iq_gen2 #(
   parameter int ALU_IMM_IQ_ENTRIES = 8,
   parameter int LOG_PR_COUNT       = 7,
   parameter int LOG_ROB_ENTRIES    = 7,
   parameter int LOG_PRF_BANK_COUNT = 2,
   localparam int PRF_BANK_COUNT    = 2 ** LOG_PRF_BANK_COUNT,
   localparam int UPPER_W           = LOG_PR_COUNT - LOG_PRF_BANK_COUNT
) (
   input  logic                                         CLK,
   input  logic                                         nRST,

   input  logic                                         iq_enq_valid,
   input  logic [3:0]                                   iq_enq_op,
   input  logic [11:0]                                  iq_enq_imm12,
   input  logic [LOG_PR_COUNT-1:0]                      iq_enq_A_PR,
   input  logic                                         iq_enq_A_ready,
   input  logic [LOG_PR_COUNT-1:0]                      iq_enq_dest_PR,
   input  logic [LOG_ROB_ENTRIES-1:0]                   iq_enq_ROB_index,
   output logic                                         iq_enq_ready,

   input  logic [PRF_BANK_COUNT-1:0]                    WB_bus_valid_by_bank,
   input  logic [PRF_BANK_COUNT-1:0][UPPER_W-1:0]       WB_bus_upper_PR_by_bank,

   output logic                                         issue_valid,
   output logic [3:0]                                   issue_op,
   output logic [11:0]                                  issue_imm12,
   output logic [LOG_PR_COUNT-1:0]                      issue_dest_PR,
   output logic [LOG_ROB_ENTRIES-1:0]                   issue_ROB_index,
   output logic                                         issue_A_forward,
   output logic [LOG_PRF_BANK_COUNT-1:0]                issue_A_bank,
   input  logic                                         issue_ready,

   output logic                                         PRF_req_A_valid,
   output logic [LOG_PR_COUNT-1:0]                      PRF_req_A_PR,

   input  logic                                         flush_valid,
   input  logic [LOG_ROB_ENTRIES-1:0]                   flush_ROB_index,
   input  logic [LOG_ROB_ENTRIES-1:0]                   ROB_head_index
);

   localparam int N     = ALU_IMM_IQ_ENTRIES;
   localparam int IDX_W = $clog2(N);
   localparam int CNT_W = $clog2(N + 1);

   typedef struct packed {
      logic                       valid;
      logic [3:0]                 op;
      logic [11:0]                imm12;
      logic [LOG_PR_COUNT-1:0]    A_PR;
      logic                       A_ready;
      logic [LOG_PR_COUNT-1:0]    dest_PR;
      logic [LOG_ROB_ENTRIES-1:0] ROB_index;
   } entry_t;

   entry_t                     q      [N];
   entry_t                     q_next [N];

   logic [N-1:0]               wake;
   logic [N-1:0]               eligible;
   logic [N-1:0]               remove;
   logic                       sel_found;
   logic [IDX_W-1:0]           sel_idx;
   logic [IDX_W-1:0]           out_idx;
   logic                       issue_fire;
   logic                       enq_fire;
   logic                       enq_wake;
   logic                       full;
   logic [LOG_ROB_ENTRIES-1:0] rel_flush;
   logic [LOG_ROB_ENTRIES-1:0] rel_entry;
   logic [CNT_W-1:0]           wr_ptr;
   entry_t                     upd;
   entry_t                     new_entry;

   // A PR matches when its bank's writeback is valid and the upper PR bits on
   // that bank equal the upper bits of the PR.
   function automatic logic wb_hit(
      input logic [LOG_PR_COUNT-1:0]                pr,
      input logic [PRF_BANK_COUNT-1:0]              bus_valid,
      input logic [PRF_BANK_COUNT-1:0][UPPER_W-1:0] bus_upper
   );
      logic [LOG_PRF_BANK_COUNT-1:0] bank;
      bank = pr[LOG_PRF_BANK_COUNT-1:0];
      return bus_valid[bank] &&
             (bus_upper[bank] == pr[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT]);
   endfunction

   // ---------------------------------------------------------------------------
   // Wakeup and eligibility
   // ---------------------------------------------------------------------------
   always_comb begin
      wake     = '0;
      eligible = '0;
      for (int i = 0; i < N; i++) begin
         wake[i] = q[i].valid &&
                   wb_hit(q[i].A_PR, WB_bus_valid_by_bank, WB_bus_upper_PR_by_bank);
`ifdef ALU_IMM_IQ_WB_FORWARD_EN
         eligible[i] = q[i].valid && (q[i].A_ready || wake[i]);
`else
         eligible[i] = q[i].valid && q[i].A_ready;
`endif
      end
   end

   assign enq_wake = wb_hit(iq_enq_A_PR, WB_bus_valid_by_bank, WB_bus_upper_PR_by_bank);

   // ---------------------------------------------------------------------------
   // Oldest-ready select: scan from the youngest toward entry 0 so the lowest
   // eligible index wins.
   // ---------------------------------------------------------------------------
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(i);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Issue and enqueue handshakes
   // ---------------------------------------------------------------------------
   assign full         = q[N-1].valid;
   assign iq_enq_ready = ~full & ~flush_valid;
   assign enq_fire     = iq_enq_valid & iq_enq_ready;

   assign issue_valid  = sel_found & ~flush_valid;
   assign issue_fire   = issue_valid & issue_ready;

   // Without an issue, the data outputs show entry 0. After reset that entry is
   // all zero, so the outputs are zero.
   assign out_idx         = issue_valid ? sel_idx : '0;
   assign issue_op        = q[out_idx].op;
   assign issue_imm12     = q[out_idx].imm12;
   assign issue_dest_PR   = q[out_idx].dest_PR;
   assign issue_ROB_index = q[out_idx].ROB_index;
   assign issue_A_bank    = q[out_idx].A_PR[LOG_PRF_BANK_COUNT-1:0];
   assign PRF_req_A_PR    = q[out_idx].A_PR;

`ifdef ALU_IMM_IQ_WB_FORWARD_EN
   // Forwarding applies only when the op became eligible through this cycle's
   // wakeup. An op that is already ready reads the PRF.
   assign issue_A_forward = issue_valid & ~q[sel_idx].A_ready & wake[sel_idx];
`else
   assign issue_A_forward = 1'b0;
`endif

   assign PRF_req_A_valid = issue_fire & ~issue_A_forward;

   // ---------------------------------------------------------------------------
   // Removal mask: a flush kills every entry whose age relative to the ROB head
   // is at or beyond the flush index. Otherwise only the issued entry leaves.
   // The subtraction wraps modulo the ROB size, which handles ROB index
   // wrap-around.
   // ---------------------------------------------------------------------------
   always_comb begin
      remove    = '0;
      rel_flush = flush_ROB_index - ROB_head_index;
      rel_entry = '0;
      for (int i = 0; i < N; i++) begin
         rel_entry = q[i].ROB_index - ROB_head_index;
         if (flush_valid) begin
            remove[i] = q[i].valid && (rel_entry >= rel_flush);
         end else begin
            remove[i] = issue_fire && (sel_idx == IDX_W'(i));
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Next state: compact survivors toward entry 0 in order and apply wakeup,
   // then append an accepted enqueue right after the last survivor. The
   // survivor count equals (count - issue_fire) when there is no flush.
   // ---------------------------------------------------------------------------
   always_comb begin
      new_entry           = '0;
      new_entry.valid     = 1'b1;
      new_entry.op        = iq_enq_op;
      new_entry.imm12     = iq_enq_imm12;
      new_entry.A_PR      = iq_enq_A_PR;
      new_entry.A_ready   = iq_enq_A_ready | enq_wake;
      new_entry.dest_PR   = iq_enq_dest_PR;
      new_entry.ROB_index = iq_enq_ROB_index;
   end

   always_comb begin
      for (int i = 0; i < N; i++) begin
         q_next[i] = '0;
      end
      wr_ptr = '0;
      upd    = '0;
      for (int i = 0; i < N; i++) begin
         upd         = q[i];
         upd.A_ready = q[i].A_ready | wake[i];
         if (q[i].valid && !remove[i]) begin
            q_next[wr_ptr[IDX_W-1:0]] = upd;
            wr_ptr = wr_ptr + CNT_W'(1);
         end
      end
      // A refused enqueue while full keeps wr_ptr out of this path, so the
      // write index stays below N.
      if (enq_fire) begin
         q_next[wr_ptr[IDX_W-1:0]] = new_entry;
      end
   end

   // ---------------------------------------------------------------------------
   // State register. Reset clears whole entries, not just the valid bits, so
   // the data outputs read zero during and right after reset.
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < N; i++) begin
            q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            q[i] <= q_next[i];
         end
      end
   end

endmodule

// File: tb/tb_alu_imm_iq_gen2.sv
// -----------------------------------------------------------------------------
// tb_alu_imm_iq_gen2
//
// Bench for alu_imm_iq_gen2 with default parameters (8 entries, 7-bit PR,
// 7-bit ROB index, 4 banks). The reference model is an ordered list of
// pending ops. Each cycle the model picks the first ready op, deletes
// issued or flushed ops, and marks woken operands ready.
// -----------------------------------------------------------------------------
module tb_alu_imm_iq_gen2;

   localparam int N = 8;

`ifdef ALU_IMM_IQ_WB_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   // ---------------------------------------------------------------- clock/reset
   logic CLK = 1'b0;
   logic nRST;
   always #5 CLK = ~CLK;

   // ---------------------------------------------------------------- DUT signals
   logic            iq_enq_valid;
   logic [3:0]      iq_enq_op;
   logic [11:0]     iq_enq_imm12;
   logic [6:0]      iq_enq_A_PR;
   logic            iq_enq_A_ready;
   logic [6:0]      iq_enq_dest_PR;
   logic [6:0]      iq_enq_ROB_index;
   logic            iq_enq_ready;
   logic [3:0]      WB_bus_valid_by_bank;
   logic [3:0][4:0] WB_bus_upper_PR_by_bank;
   logic            issue_valid;
   logic [3:0]      issue_op;
   logic [11:0]     issue_imm12;
   logic [6:0]      issue_dest_PR;
   logic [6:0]      issue_ROB_index;
   logic            issue_A_forward;
   logic [1:0]      issue_A_bank;
   logic            issue_ready;
   logic            PRF_req_A_valid;
   logic [6:0]      PRF_req_A_PR;
   logic            flush_valid;
   logic [6:0]      flush_ROB_index;
   logic [6:0]      ROB_head_index;

   alu_imm_iq_gen2 dut (
      .CLK                     (CLK),
      .nRST                    (nRST),
      .iq_enq_valid            (iq_enq_valid),
      .iq_enq_op               (iq_enq_op),
      .iq_enq_imm12            (iq_enq_imm12),
      .iq_enq_A_PR             (iq_enq_A_PR),
      .iq_enq_A_ready          (iq_enq_A_ready),
      .iq_enq_dest_PR          (iq_enq_dest_PR),
      .iq_enq_ROB_index        (iq_enq_ROB_index),
      .iq_enq_ready            (iq_enq_ready),
      .WB_bus_valid_by_bank    (WB_bus_valid_by_bank),
      .WB_bus_upper_PR_by_bank (WB_bus_upper_PR_by_bank),
      .issue_valid             (issue_valid),
      .issue_op                (issue_op),
      .issue_imm12             (issue_imm12),
      .issue_dest_PR           (issue_dest_PR),
      .issue_ROB_index         (issue_ROB_index),
      .issue_A_forward         (issue_A_forward),
      .issue_A_bank            (issue_A_bank),
      .issue_ready             (issue_ready),
      .PRF_req_A_valid         (PRF_req_A_valid),
      .PRF_req_A_PR            (PRF_req_A_PR),
      .flush_valid             (flush_valid),
      .flush_ROB_index         (flush_ROB_index),
      .ROB_head_index          (ROB_head_index)
   );

   // ---------------------------------------------------------------- checking
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- reference model
   typedef struct {
      logic [3:0]  op;
      logic [11:0] imm;
      logic [6:0]  a_pr;
      bit          a_ready;
      logic [6:0]  dest;
      logic [6:0]  rob;
   } m_ent_t;

   m_ent_t     mq[$];
   int         m_sel;
   bit         m_iv, m_fwd, m_enq_rdy;

   // scoreboard of expected issue order for the ordering scenario
   logic [3:0] exp_q[$];
   bit         sb_on = 1'b0;

   function automatic bit wb_match(input logic [6:0] pr);
      int bank;
      bank = int'(pr) % 4;
      return WB_bus_valid_by_bank[bank] && (int'(WB_bus_upper_PR_by_bank[bank]) == int'(pr) / 4);
   endfunction

   function automatic int rel(input logic [6:0] x);
      return (int'(x) - int'(ROB_head_index) + 128) % 128;
   endfunction

   task automatic model_eval();
      m_enq_rdy = (mq.size() < N) && !flush_valid;
      m_iv  = 1'b0;
      m_sel = 0;
      m_fwd = 1'b0;
      if (!flush_valid) begin
         foreach (mq[i]) begin
            if (!m_iv && (mq[i].a_ready || (FWD && wb_match(mq[i].a_pr)))) begin
               m_iv  = 1'b1;
               m_sel = i;
            end
         end
      end
      if (m_iv) m_fwd = !mq[m_sel].a_ready;
   endtask

   task automatic model_update();
      bit     fire, enq;
      m_ent_t e;
      fire = m_iv && issue_ready;
      enq  = iq_enq_valid && m_enq_rdy;
      if (flush_valid) begin
         for (int i = mq.size() - 1; i >= 0; i--)
            if (rel(mq[i].rob) >= rel(flush_ROB_index)) mq.delete(i);
      end else if (fire) begin
         mq.delete(m_sel);
      end
      foreach (mq[i]) if (wb_match(mq[i].a_pr)) mq[i].a_ready = 1'b1;
      if (enq) begin
         e.op      = iq_enq_op;
         e.imm     = iq_enq_imm12;
         e.a_pr    = iq_enq_A_PR;
         e.a_ready = iq_enq_A_ready || wb_match(iq_enq_A_PR);
         e.dest    = iq_enq_dest_PR;
         e.rob     = iq_enq_ROB_index;
         mq.push_back(e);
      end
   endtask

   task automatic compare();
      check("enq_ready",   iq_enq_ready,    m_enq_rdy);
      check("issue_valid", issue_valid,     m_iv);
      check("issue_fwd",   issue_A_forward, m_fwd);
      check("prf_valid",   PRF_req_A_valid, m_iv && issue_ready && !m_fwd);
      if (m_iv) begin
         check("issue_op",   issue_op,        mq[m_sel].op);
         check("issue_imm",  issue_imm12,     mq[m_sel].imm);
         check("issue_dest", issue_dest_PR,   mq[m_sel].dest);
         check("issue_rob",  issue_ROB_index, mq[m_sel].rob);
         check("issue_bank", issue_A_bank,    mq[m_sel].a_pr[1:0]);
         check("prf_pr",     PRF_req_A_PR,    mq[m_sel].a_pr);
      end
      if (sb_on && issue_valid && issue_ready) begin
         check("sb_pending", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) check("sb_order", issue_op, exp_q.pop_front());
      end
   endtask

   // ---------------------------------------------------------------- driver tasks
   task automatic idle();
      iq_enq_valid            = 1'b0;
      iq_enq_op               = '0;
      iq_enq_imm12            = '0;
      iq_enq_A_PR             = '0;
      iq_enq_A_ready          = 1'b0;
      iq_enq_dest_PR          = '0;
      iq_enq_ROB_index        = '0;
      WB_bus_valid_by_bank    = '0;
      WB_bus_upper_PR_by_bank = '0;
      issue_ready             = 1'b0;
      flush_valid             = 1'b0;
      flush_ROB_index         = '0;
      ROB_head_index          = '0;
   endtask

   task automatic drive_enq(input logic [3:0] op, input logic [11:0] imm, input logic [6:0] pr,
                            input logic rdy, input logic [6:0] dest, input logic [6:0] rob);
      iq_enq_valid     = 1'b1;
      iq_enq_op        = op;
      iq_enq_imm12     = imm;
      iq_enq_A_PR      = pr;
      iq_enq_A_ready   = rdy;
      iq_enq_dest_PR   = dest;
      iq_enq_ROB_index = rob;
   endtask

   // One clock: check outputs at the falling edge, then advance the model at
   // the rising edge. Returns 1 time unit after the rising edge.
   task automatic step();
      @(negedge CLK);
      model_eval();
      compare();
      @(posedge CLK);
      model_update();
      #1;
   endtask

   // Drops nRST just after a rising edge, checks the reset outputs while nRST
   // is low, and releases it after the next rising edge.
   task automatic do_reset();
      idle();
      nRST = 1'b0;
      #1;
      check("rst_issue_valid", issue_valid,     0);
      check("rst_enq_ready",   iq_enq_ready,    1);
      check("rst_issue_op",    issue_op,        0);
      check("rst_issue_imm",   issue_imm12,     0);
      check("rst_issue_dest",  issue_dest_PR,   0);
      check("rst_issue_rob",   issue_ROB_index, 0);
      check("rst_issue_bank",  issue_A_bank,    0);
      check("rst_issue_fwd",   issue_A_forward, 0);
      check("rst_prf_valid",   PRF_req_A_valid, 0);
      check("rst_prf_pr",      PRF_req_A_PR,    0);
      mq.delete();
      exp_q.delete();
      @(posedge CLK);
      #1;
      nRST = 1'b1;
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      idle();
      nRST = 1'b0;
      #1;
      do_reset();

      // Single ready op issues the cycle after enqueue.
      issue_ready = 1'b1;
      drive_enq(4'h2, 12'h7FF, 7'd5, 1'b1, 7'd10, 7'd3);
      step();
      idle();
      issue_ready = 1'b1;
      #1;
      check("t1_valid",     issue_valid,     1);
      check("t1_imm",       issue_imm12,     12'h7FF);
      check("t1_bank",      issue_A_bank,    1);
      check("t1_prf_valid", PRF_req_A_valid, 1);
      check("t1_prf_pr",    PRF_req_A_PR,    5);
      step();

      // Fill all entries as not ready, then wake only entry 5 (PR 14).
      do_reset();
      issue_ready = 1'b1;
      for (int i = 0; i < N; i++) begin
         drive_enq(4'(i), 12'(i), (i == 5) ? 7'd14 : 7'(32 + i), 1'b0, 7'(i), 7'(i));
         step();
      end
      idle();
      issue_ready = 1'b1;
      drive_enq(4'hF, 12'h123, 7'd1, 1'b1, 7'd1, 7'd9);
      #1;
      check("t2_full", iq_enq_ready, 0);
      step();
      idle();
      issue_ready                = 1'b1;
      WB_bus_valid_by_bank       = 4'b0100;
      WB_bus_upper_PR_by_bank[2] = 5'd3;
      #1;
      check("t2_wake_iv",  issue_valid,     FWD);
      check("t2_wake_fwd", issue_A_forward, FWD);
      check("t2_wake_prf", PRF_req_A_valid, 0);
      step();
      idle();
      issue_ready = 1'b1;
      #1;
      check("t2_late_iv", issue_valid, !FWD);
      step();

      // Entries 0 and 2 ready; the pipeline stalls for two cycles.
      do_reset();
      drive_enq(4'hA, 12'h00A, 7'd40, 1'b1, 7'd1, 7'd1); step();
      drive_enq(4'hB, 12'h00B, 7'd41, 1'b0, 7'd2, 7'd2); step();
      drive_enq(4'hC, 12'h00C, 7'd42, 1'b1, 7'd3, 7'd3); step();
      idle();
      step();
      step();
      sb_on = 1'b1;
      exp_q.push_back(4'hA);
      exp_q.push_back(4'hC);
      issue_ready = 1'b1;
      step();
      step();
      step();
      check("t3_sb_drained", exp_q.size(), 0);
      sb_on = 1'b0;

      // ROB-relative flush across the index wrap.
      do_reset();
      ROB_head_index = 7'd120;
      drive_enq(4'h1, 12'h001, 7'd50, 1'b1, 7'd1, 7'd125); step();
      drive_enq(4'h2, 12'h002, 7'd51, 1'b1, 7'd2, 7'd2);   step();
      drive_enq(4'h3, 12'h003, 7'd52, 1'b1, 7'd3, 7'd6);   step();
      drive_enq(4'h4, 12'h004, 7'd53, 1'b1, 7'd4, 7'd7);
      flush_valid     = 1'b1;
      flush_ROB_index = 7'd1;
      issue_ready     = 1'b1;
      #1;
      check("t4_flush_iv",  issue_valid,  0);
      check("t4_flush_enq", iq_enq_ready, 0);
      step();
      idle();
      ROB_head_index = 7'd120;
      issue_ready    = 1'b1;
      #1;
      check("t4_surv_iv",  issue_valid,     1);
      check("t4_surv_rob", issue_ROB_index, 125);
      step();
      #1;
      check("t4_empty_iv", issue_valid, 0);
      step();

      // Enqueue while the same-cycle writeback matches the incoming A_PR.
      do_reset();
      issue_ready = 1'b1;
      drive_enq(4'h7, 12'h0F0, 7'd9, 1'b0, 7'd20, 7'd30);
      WB_bus_valid_by_bank       = 4'b0010;
      WB_bus_upper_PR_by_bank[1] = 5'd2;
      step();
      idle();
      issue_ready = 1'b1;
      #1;
      check("t5_iv",     issue_valid,     1);
      check("t5_fwd",    issue_A_forward, 0);
      check("t5_prf",    PRF_req_A_valid, 1);
      check("t5_prf_pr", PRF_req_A_PR,    9);
      step();

      // Reset in the middle of a full queue.
      do_reset();
      for (int i = 0; i < N; i++) begin
         drive_enq(4'(i + 3), 12'(i), 7'(i), 1'b1, 7'(i), 7'(i));
         step();
      end
      do_reset();
      issue_ready = 1'b1;
      step();
      step();

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         idle();
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            if ($urandom_range(0, 9) < 7)
               drive_enq(4'($urandom_range(0, 15)), 12'($urandom_range(0, 4095)),
                         7'($urandom_range(0, 15)), 1'($urandom_range(0, 9) < 3),
                         7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)));
            issue_ready = ($urandom_range(0, 9) < 7);
            for (int b = 0; b < 4; b++) begin
               WB_bus_valid_by_bank[b]    = ($urandom_range(0, 9) < 3);
               WB_bus_upper_PR_by_bank[b] = 5'($urandom_range(0, 3));
            end
            ROB_head_index = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 19) == 0) begin
               flush_valid     = 1'b1;
               flush_ROB_index = 7'($urandom_range(0, 127));
            end
            step();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
